// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int SRAM_ADDR_W = 17;
    localparam int SRAM_DATA_W = 16;

endpackage

// File: rtl/sram_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping modulo N_PORTS.
module sram_rr_pick #(
    parameter int N_PORTS = 3,
    parameter int IDX_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;
    logic             hit;

    // Walk offsets 0..N_PORTS-1 from ptr; the earliest hit keeps priority.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        pos   = '0;
        hit   = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            sum   = {1'b0, ptr} + (IDX_W+1)'(i);
            pos   = (sum >= (IDX_W+1)'(N_PORTS)) ? IDX_W'(sum - (IDX_W+1)'(N_PORTS)) : IDX_W'(sum);
            hit   = !valid && req[pos];
            idx   = hit ? pos : idx;
            valid = valid | hit;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of one SRAM controller among N_PORTS clients, with a
// latched command and a per-transaction timeout.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N_PORTS        = 3,
    parameter int ADDR_W         = SRAM_ADDR_W,
    parameter int DATA_W         = SRAM_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS-1:0]        we,
    input  logic [N_PORTS*ADDR_W-1:0] addr,
    input  logic [N_PORTS*DATA_W-1:0] wdata,
    output logic [N_PORTS-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic                      busy,
    output logic                      mem_read_req,
    output logic                      mem_write_req,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ready
);

    localparam int IDX_W = $clog2(N_PORTS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PORTS - 1);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  rr_ptr;
    logic              we_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;

    sram_rr_pick #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a ready pulse in the expiry cycle takes precedence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = pick_valid ? ISSUE : IDLE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (mem_ready || (cnt == CNT_LAST)) begin
                    state_next = DONE;
                end else begin
                    state_next = WAIT;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command latch, timeout counter, completion capture and pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            we_q      <= 1'b0;
            cnt       <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_idx   <= pick_idx;
                        we_q      <= we[pick_idx];
                        mem_addr  <= addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        mem_wdata <= wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_ready) begin
                        rdata_q <= we_q ? '0 : mem_rdata;
                        err_q   <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                DONE: rr_ptr <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

    // Outputs decoded from the state register and latched data only.
    always_comb begin
        ack   = '0;
        rdata = '0;
        err   = 1'b0;
        if (state == DONE) begin
            ack[gnt_idx] = 1'b1;
            rdata        = rdata_q;
            err          = err_q;
        end else begin
            ack   = '0;
            rdata = '0;
            err   = 1'b0;
        end
    end

    assign busy          = (state != IDLE);
    assign mem_read_req  = (state == ISSUE) && !we_q;
    assign mem_write_req = (state == ISSUE) && we_q;

endmodule
